// File: rtl/cache_pkg.sv
// Shared types and width helpers for the parametrised set-associative data cache.
package cache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  // Word-offset bits inside a block.
  function automatic int OFF_W(input int block_size);
    return $clog2(block_size);
  endfunction

  // Set-index bits.
  function automatic int IDX_W(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag bits: whatever is left above index, offset and byte bits.
  function automatic int TAG_W(input int block_size, input int num_sets);
    return WORD_W - 2 - $clog2(block_size) - $clog2(num_sets);
  endfunction

  // Age and way-number width; a direct-mapped cache still keeps one bit.
  function automatic int AGE_W(input int assoc);
    return (assoc > 1) ? $clog2(assoc) : 1;
  endfunction

endpackage

// File: rtl/assoc_data_cache_if.sv
// CPU-side and memory-side signals of the data cache. The slave modport is the
// cache itself; the master modport is its environment (pipeline plus memory).
interface assoc_data_cache_if
  import cache_pkg::*;
#(
  parameter int BLOCK_SIZE = 8
);

  logic                         cpu_read;
  logic                         cpu_write;
  logic [WORD_W-1:0]            cpu_addr;
  logic [WORD_W-1:0]            cpu_wdata;
  logic [WORD_W-1:0]            cpu_rdata;
  logic                         cpu_busywait;

  logic                         mem_read;
  logic                         mem_write;
  logic [WORD_W-1:0]            mem_addr;
  logic [WORD_W*BLOCK_SIZE-1:0] mem_wdata;
  logic [WORD_W*BLOCK_SIZE-1:0] mem_rdata;
  logic                         mem_busywait;

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_busywait,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_busywait
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_busywait,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_busywait
  );

endinterface

// File: rtl/cache_lru_ages.sv
// True-LRU age tracking: one age per way per set, ages in a set always form a
// permutation of 0..ASSOCIATIVITY-1 and the oldest way is the replacement victim.
module cache_lru_ages
  import cache_pkg::*;
#(
  parameter int ASSOCIATIVITY = 2,
  parameter int NUM_SETS      = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [IDX_W(NUM_SETS)-1:0]          set_idx,
  input  logic [AGE_W(ASSOCIATIVITY)-1:0]     access_way,
  input  logic                                update,
  output logic [AGE_W(ASSOCIATIVITY)-1:0]     victim_way
);

  localparam int AW = AGE_W(ASSOCIATIVITY);

  logic [AW-1:0] ages [NUM_SETS][ASSOCIATIVITY];

  // Reset seeds age = way number; a hit makes its way youngest and ages the younger ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
          ages[s][w] <= AW'(w);
        end
      end
    end else if (update) begin
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
        if (AW'(w) == access_way) begin
          ages[set_idx][w] <= '0;
        end else if (ages[set_idx][w] < ages[set_idx][access_way]) begin
          ages[set_idx][w] <= ages[set_idx][w] + 1'b1;
        end
      end
    end
  end

  // The victim is the way whose age has reached the maximum.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (ages[set_idx][w] == AW'(ASSOCIATIVITY - 1)) begin
        victim_way = AW'(w);
      end
    end
  end

endmodule

// File: rtl/assoc_data_cache.sv
// N-way set-associative, write-back, write-allocate data cache with true-LRU
// replacement, dirty-victim writeback and saturating hit/miss counters.
module assoc_data_cache
  import cache_pkg::*;
#(
  parameter int ASSOCIATIVITY = 2,
  parameter int BLOCK_SIZE    = 8,
  parameter int NUM_SETS      = 8
) (
  input  logic              clk,
  input  logic              reset,
  assoc_data_cache_if.slave bus,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
);

  localparam int OW = OFF_W(BLOCK_SIZE);
  localparam int IW = IDX_W(NUM_SETS);
  localparam int TW = TAG_W(BLOCK_SIZE, NUM_SETS);
  localparam int AW = AGE_W(ASSOCIATIVITY);
  localparam int BW = WORD_W * BLOCK_SIZE;
  localparam int SW = OW + 5;

  cache_state_t      state;
  logic              valid  [NUM_SETS][ASSOCIATIVITY];
  logic              dirty  [NUM_SETS][ASSOCIATIVITY];
  logic [TW-1:0]     tags   [NUM_SETS][ASSOCIATIVITY];
  logic [BW-1:0]     blocks [NUM_SETS][ASSOCIATIVITY];

  logic [OW-1:0]     req_off;
  logic [IW-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic              req;
  logic [SW-1:0]     word_lsb;

  logic              hit;
  logic [AW-1:0]     hit_way;
  logic [BW-1:0]     hit_blk;
  logic              has_invalid;
  logic [AW-1:0]     inv_way;
  logic [AW-1:0]     lru_victim;
  logic [AW-1:0]     miss_way;

  logic [AW-1:0]     vic_way;
  logic [IW-1:0]     lat_idx;
  logic [TW-1:0]     lat_tag;

  logic              mem_read_q;
  logic              mem_write_q;
  logic [WORD_W-1:0] mem_addr_q;

  logic              write_hit;
  logic              fill_en;
  logic              lru_update;
  logic              unused_addr_bits;

  assign req_off          = bus.cpu_addr[OW+1:2];
  assign req_idx          = bus.cpu_addr[OW+IW+1:OW+2];
  assign req_tag          = bus.cpu_addr[WORD_W-1:OW+IW+2];
  assign req              = bus.cpu_read | bus.cpu_write;
  assign word_lsb         = {req_off, 5'b00000};
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (valid[req_idx][w] && (tags[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins over the LRU victim.
  always_comb begin
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) begin
        has_invalid = 1'b1;
        inv_way     = AW'(w);
      end
    end
  end

  assign miss_way   = has_invalid ? inv_way : lru_victim;
  assign hit_blk    = blocks[req_idx][hit_way];
  assign lru_update = (state == IDLE) && req && hit;
  assign write_hit  = (state == IDLE) && bus.cpu_write && hit && !reset;
  assign fill_en    = (state == ALLOCATE) && !bus.mem_busywait && !reset;

  assign bus.cpu_rdata    = hit ? hit_blk[word_lsb +: WORD_W] : '0;
  assign bus.cpu_busywait = (state != IDLE) || (req && !hit);
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = blocks[lat_idx][vic_way];

  cache_lru_ages #(
    .ASSOCIATIVITY(ASSOCIATIVITY),
    .NUM_SETS     (NUM_SETS)
  ) u_lru (
    .clk       (clk),
    .reset     (reset),
    .set_idx   (req_idx),
    .access_way(hit_way),
    .update    (lru_update),
    .victim_way(lru_victim)
  );

  // Data and tag arrays: block fill from memory or single-word CPU write on a hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      blocks[lat_idx][vic_way] <= bus.mem_rdata;
      tags[lat_idx][vic_way]   <= lat_tag;
    end else if (write_hit) begin
      blocks[req_idx][hit_way][word_lsb +: WORD_W] <= bus.cpu_wdata;
    end
  end

  // Miss-handling FSM with registered memory strobes, valid/dirty bits and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      vic_way     <= '0;
      lat_idx     <= '0;
      lat_tag     <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
              if (bus.cpu_write) dirty[req_idx][hit_way] <= 1'b1;
            end else begin
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
              vic_way <= miss_way;
              lat_idx <= req_idx;
              lat_tag <= req_tag;
              if (valid[req_idx][miss_way] && dirty[req_idx][miss_way]) begin
                state       <= WRITEBACK;
                mem_write_q <= 1'b1;
                mem_addr_q  <= {tags[req_idx][miss_way], req_idx, {(OW+2){1'b0}}};
              end else begin
                state      <= ALLOCATE;
                mem_read_q <= 1'b1;
                mem_addr_q <= {req_tag, req_idx, {(OW+2){1'b0}}};
              end
            end
          end
        end
        WRITEBACK: begin
          if (!bus.mem_busywait) begin
            state       <= ALLOCATE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {lat_tag, lat_idx, {(OW+2){1'b0}}};
          end
        end
        ALLOCATE: begin
          if (!bus.mem_busywait) begin
            state                   <= IDLE;
            mem_read_q              <= 1'b0;
            valid[lat_idx][vic_way] <= 1'b1;
            dirty[lat_idx][vic_way] <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed self-checking bench for assoc_data_cache: a 2-way instance for the
// main sequences and a direct-mapped instance for thrashing and saturation.
module tb_assoc_data_cache;
  import cache_pkg::*;

  localparam int BS    = 8;
  localparam int BW    = WORD_W * BS;
  localparam int LIMIT = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              sel_dm;
  logic [31:0]       hit_count, miss_count, hit_count_dm, miss_count_dm;

  int                checks = 0;
  int                passes = 0;
  int                mcnt = 0;
  int                mcnt_dm = 0;
  int                rd_cycles = 0;
  int                wr_cycles = 0;
  logic [31:0]       rd_addr = '0;
  logic [31:0]       wr_addr = '0;
  logic [BW-1:0]     wr_data = '0;
  int                stall, rd_delta, wr_delta;
  logic [31:0]       rdata;

  assoc_data_cache_if #(.BLOCK_SIZE(BS)) bus ();
  assoc_data_cache_if #(.BLOCK_SIZE(BS)) bus_dm ();

  assoc_data_cache #(.ASSOCIATIVITY(2), .BLOCK_SIZE(BS), .NUM_SETS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );

  assoc_data_cache #(.ASSOCIATIVITY(1), .BLOCK_SIZE(BS), .NUM_SETS(8)) dut_dm (
    .clk(clk), .reset(reset), .bus(bus_dm), .hit_count(hit_count_dm), .miss_count(miss_count_dm)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  assign bus.cpu_read     = cpu_read;
  assign bus.cpu_write    = cpu_write;
  assign bus.cpu_addr     = cpu_addr;
  assign bus.cpu_wdata    = cpu_wdata;
  assign bus_dm.cpu_read  = cpu_read;
  assign bus_dm.cpu_write = cpu_write;
  assign bus_dm.cpu_addr  = cpu_addr;
  assign bus_dm.cpu_wdata = cpu_wdata;

  // Fill pattern: word i of a block = 0xC0DE0000 + low address bits + i.
  function automatic logic [BW-1:0] fill_block(input logic [31:0] addr);
    logic [BW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*32 +: 32] = 32'hC0DE_0000 + {16'h0, addr[15:0]} + 32'(i);
    return b;
  endfunction

  assign bus.mem_rdata       = fill_block(bus.mem_addr);
  assign bus.mem_busywait    = (bus.mem_read || bus.mem_write) && (mcnt != 3);
  assign bus_dm.mem_rdata    = fill_block(bus_dm.mem_addr);
  assign bus_dm.mem_busywait = (bus_dm.mem_read || bus_dm.mem_write) && (mcnt_dm != 3);

  // Memory model: three busy cycles then one acknowledge cycle per strobe phase.
  always @(posedge clk) begin
    if (bus.mem_read || bus.mem_write) mcnt <= (mcnt == 3) ? 0 : mcnt + 1;
    else mcnt <= 0;
    if (bus_dm.mem_read || bus_dm.mem_write) mcnt_dm <= (mcnt_dm == 3) ? 0 : mcnt_dm + 1;
    else mcnt_dm <= 0;
  end

  // Memory-side monitor of the 2-way instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_read) begin
      rd_cycles++;
      rd_addr = bus.mem_addr;
    end
    if (bus.mem_write) begin
      wr_cycles++;
      wr_addr = bus.mem_addr;
      wr_data = bus.mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  function automatic logic busy();
    return sel_dm ? bus_dm.cpu_busywait : bus.cpu_busywait;
  endfunction

  function automatic logic [31:0] cur_rdata();
    return sel_dm ? bus_dm.cpu_rdata : bus.cpu_rdata;
  endfunction

  // One CPU access held until busywait drops; reports stall cycles and memory activity.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int rd0, wr0;
    @(negedge clk);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
    rd0   = rd_cycles;
    wr0   = wr_cycles;
    stall = 0;
    while (busy() && stall < LIMIT) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (stall >= LIMIT) checkOutput("busywait_timeout", {31'b0, busy()}, 32'd0);
    rdata = cur_rdata();
    @(negedge clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    #1;
    rd_delta = rd_cycles - rd0;
    wr_delta = wr_cycles - wr0;
  endtask

  // Directed sequence.
  initial begin
    int dm_addrs [4];
    dm_addrs = '{32'h40, 32'h140, 32'h40, 32'h140};
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0; sel_dm = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_hit_count", hit_count, 32'd0);
    checkOutput("rst_miss_count", miss_count, 32'd0);
    checkOutput("rst_busywait", {31'b0, bus.cpu_busywait}, 32'd0);
    checkOutput("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
    checkOutput("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("t1_stall", 32'(stall), 32'd5);
    checkOutput("t1_rd_cycles", 32'(rd_delta), 32'd4);
    checkOutput("t1_wr_cycles", 32'(wr_delta), 32'd0);
    checkOutput("t1_rd_addr", rd_addr, 32'h40);
    checkOutput("t1_rdata", rdata, 32'hC0DE_0040);
    checkOutput("t1_miss", miss_count, 32'd1);
    checkOutput("t1_hit", hit_count, 32'd1);

    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0);
    checkOutput("t2_stall", 32'(stall), 32'd0);
    checkOutput("t2_rdata", rdata, 32'hC0DE_0041);
    checkOutput("t2_hit", hit_count, 32'd2);

    applyStimulus(1'b0, 1'b1, 32'h48, 32'hDEAD_BEEF);
    checkOutput("t3_wr_stall", 32'(stall), 32'd0);
    checkOutput("t3_wr_mem", 32'(rd_delta + wr_delta), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h4C, 32'h1234_5678);
    checkOutput("t3_both_stall", 32'(stall), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h48, 32'h0);
    checkOutput("t3_rd48", rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h4C, 32'h0);
    checkOutput("t3_rd4c", rdata, 32'h1234_5678);
    checkOutput("t3_hit", hit_count, 32'd6);
    checkOutput("t3_miss", miss_count, 32'd1);

    applyStimulus(1'b1, 1'b0, 32'h140, 32'h0);
    checkOutput("t4_140_stall", 32'(stall), 32'd5);
    checkOutput("t4_140_rdata", rdata, 32'hC0DE_0140);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("t4_touch_stall", 32'(stall), 32'd0);
    checkOutput("t4_touch_rdata", rdata, 32'hC0DE_0040);
    applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
    checkOutput("t4_240_stall", 32'(stall), 32'd5);
    checkOutput("t4_240_wr_cycles", 32'(wr_delta), 32'd0);
    checkOutput("t4_240_rdata", rdata, 32'hC0DE_0240);
    applyStimulus(1'b1, 1'b0, 32'h340, 32'h0);
    checkOutput("t4_340_stall", 32'(stall), 32'd9);
    checkOutput("t4_340_wr_cycles", 32'(wr_delta), 32'd4);
    checkOutput("t4_340_rd_cycles", 32'(rd_delta), 32'd4);
    checkOutput("t4_wb_addr", wr_addr, 32'h40);
    checkOutput("t4_wb_word0", wr_data[31:0], 32'hC0DE_0040);
    checkOutput("t4_wb_word2", wr_data[95:64], 32'hDEAD_BEEF);
    checkOutput("t4_wb_word3", wr_data[127:96], 32'h1234_5678);
    checkOutput("t4_fill_addr", rd_addr, 32'h340);
    checkOutput("t4_340_rdata", rdata, 32'hC0DE_0340);
    applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
    checkOutput("t4_240_kept", 32'(stall), 32'd0);
    checkOutput("t4_miss", miss_count, 32'd4);
    checkOutput("t4_hit", hit_count, 32'd11);

    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 32'h40;
    @(negedge clk);
    checkOutput("t5_alloc_mem_read", {31'b0, bus.mem_read}, 32'd1);
    reset    = 1'b1;
    cpu_read = 1'b0;
    @(negedge clk);
    checkOutput("t5_mem_read", {31'b0, bus.mem_read}, 32'd0);
    checkOutput("t5_mem_write", {31'b0, bus.mem_write}, 32'd0);
    checkOutput("t5_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("t5_busywait", {31'b0, bus.cpu_busywait}, 32'd0);
    checkOutput("t5_hit", hit_count, 32'd0);
    checkOutput("t5_miss", miss_count, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("t5_reread_stall", 32'(stall), 32'd5);
    checkOutput("t5_reread_rdata", rdata, 32'hC0DE_0040);
    checkOutput("t5_reread_miss", miss_count, 32'd1);

    sel_dm = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, dm_addrs[i], 32'h0);
      checkOutput($sformatf("t6_stall_%0d", i), 32'(stall), 32'd5);
      checkOutput($sformatf("t6_rdata_%0d", i), rdata, 32'hC0DE_0000 + dm_addrs[i]);
    end
    checkOutput("t6_miss", miss_count_dm, 32'd4);
    checkOutput("t6_hit", hit_count_dm, 32'd4);
    force dut_dm.miss_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_dm.miss_count;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("t6_sat_stall", 32'(stall), 32'd5);
    checkOutput("t6_sat_miss", miss_count_dm, 32'hFFFF_FFFF);
    checkOutput("t6_sat_hit", hit_count_dm, 32'd5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/assoc_data_cache.md
Name: assoc_data_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache between the RV32IM MEM stage and block-wide main memory. It generalises the fixed 2-way/8-word cache configuration: associativity, block size and set count are all parameters. It adds true-LRU replacement, dirty-victim writeback and saturating hit/miss performance counters. The CPU stalls on cpu_busywait; memory handshakes on mem_busywait.

Parameters:
ASSOCIATIVITY, 2, ways per set; power of two, >=1 (1 = direct-mapped)
BLOCK_SIZE, 8, 32-bit words per block; power of two, >=2
NUM_SETS, 8, sets; power of two, >=2

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
cpu_read  in  1  word read request, held until cpu_busywait low
cpu_write  in  1  word write request, held until cpu_busywait low
cpu_addr  in  32  byte address; [1:0] ignored
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid while cpu_read=1 and cpu_busywait=0
cpu_busywait  out  1  stall to pipeline
mem_read  out  1  block fill request
mem_write  out  1  block writeback request
mem_addr  out  32  block-aligned address (offset bits zero)
mem_wdata  out  32*BLOCK_SIZE  victim block, word 0 in LSBs
mem_rdata  in  32*BLOCK_SIZE  fill block, word 0 in LSBs
mem_busywait  in  1  memory busy; data/ack valid on first cycle low while strobe high
hit_count  out  32  saturating hit counter
miss_count  out  32  saturating miss counter

Behaviour:
- Address split: word offset = cpu_addr[OFF+1:2] with OFF = log2(BLOCK_SIZE); index = next log2(NUM_SETS) bits; tag = the remaining upper bits.
- Per way/set state: valid, dirty, tag, data block, age of max(1, log2(ASSOCIATIVITY)) bits.
- Reset: all valid/dirty cleared; age[w] = w in every set; FSM to IDLE; cpu_busywait=0, mem_read=0, mem_write=0, mem_addr=0, hit_count=0, miss_count=0. Reset asserted in any state aborts the transaction at that edge. The strobes are low in the following cycle, and the cache contents are lost.
- cpu_read and cpu_write both high: treated as a write.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: busywait 0, no state change.
- IDLE, hit (valid and tag match in some way):
  - cpu_busywait=0 combinationally; cpu_rdata is the combinational word.
  - At the edge: a write updates the word and sets dirty; the LRU update is applied; hit_count increments.
  - Zero-stall latency.
- IDLE, miss:
  - cpu_busywait=1 combinationally; miss_count increments once at that edge.
  - Victim = lowest-numbered invalid way, else the way with age = ASSOCIATIVITY-1.
  - Next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
  - The victim way and request address are latched.
- WRITEBACK: mem_write=1, mem_addr={victim tag, index, 0}, mem_wdata=victim block. Held until a cycle with mem_busywait=0, then go to ALLOCATE.
- ALLOCATE:
  - mem_read=1, mem_addr={req tag, index, 0}.
  - On the mem_busywait=0 cycle, capture mem_rdata into the victim way: valid=1, dirty=0, tag written. Then go to IDLE.
  - The held request now hits, so miss latency = 1 + WB + fill cycles, plus the hit cycle. That hit increments hit_count as well.
- cpu_busywait is 1 in WRITEBACK and ALLOCATE.
- LRU update on every hit: accessed way age <- 0; ways with age < old age increment; others unchanged. Ages within a set always form a permutation.
- Request dropped mid-miss: the fill still completes; no CPU write is performed.
- Counters saturate at 0xFFFF_FFFF, with no wrap-around.
- Strobes are registered from state (glitch-free); mem_addr/mem_wdata are stable while a strobe is high.

Decomposition:
- Shared package cache_pkg:
  - state enum (IDLE/WRITEBACK/ALLOCATE);
  - width helper functions: OFF_W, IDX_W, TAG_W, AGE_W;
  - word width constant 32.
- Sub-module cache_lru_ages:
  - holds the per-set age array;
  - inputs: set index, accessed way, update strobe, reset;
  - outputs: victim (oldest) way of the addressed set.

Test Plan (defaults: index = addr[7:5], tag = addr[31:8]; memory model holds mem_busywait 3 cycles):
1. Reset, read 0x0000_0040 -> miss: mem_read=1 with mem_addr=0x40 for 3 busy cycles plus 1 ack cycle, no mem_write. cpu_rdata = fill word 0, miss_count=1, hit_count=1.
2. Next read 0x44 -> cpu_busywait=0 in the same cycle; cpu_rdata = fill word 1; hit_count=2.
3. Write 0x48 with 0xDEADBEEF -> zero-stall hit; read 0x48 returns 0xDEADBEEF; no memory activity.
4. Conflict sequence in set 2:
   - 0x140 fills way1; touch 0x40; 0x240 evicts way1 (clean, no mem_write).
   - 0x340 evicts way0 (dirty): mem_write with mem_addr=0x40 and mem_wdata word2=0xDEADBEEF, then mem_read with mem_addr=0x340.
5. Reset asserted during ALLOCATE -> mem_read=0 the next cycle, outputs at reset values; re-read 0x40 misses again.
6. Instance with ASSOCIATIVITY=1: alternate reads 0x40/0x140 ×4 -> every access misses, miss_count=4; a stuck counter forced to 0xFFFF_FFFF stays there after another miss.
